// File: rtl/tmc4671_spi_responder.sv
// SPI slave model of the TMC4671 40-bit datagram register interface.
// Oversamples SCK/nSCS/MOSI on clk, decodes write/read datagrams and serves a small register file.
module tmc4671_spi_responder #(
   parameter int unsigned REG_DEPTH   = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        SCK,
   input  logic        MOSI,
   input  logic        nSCS,
   output logic        MISO,
   output logic        miso_oe,
   output logic        wr_valid,
   output logic [6:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        rd_valid,
   output logic        frame_error,
   output logic        busy,
   input  logic [6:0]  host_addr,
   output logic [31:0] host_rdata
);

   // state  | meaning
   // S_IDLE | no frame; waiting for nSCS fall
   // S_ADDR | shifting in R/W bit and 7-bit address, MISO held 0
   // S_DATA | shifting in 32 data bits, shifting out tx word
   // S_DONE | 40 bits received; commit once, ignore SCK until nSCS rises
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   localparam int unsigned AW     = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
   localparam logic [7:0]  DEPTH8 = 8'(REG_DEPTH);

   state_t r_state;
   state_t w_state_next;

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_d;
   logic                   r_cs_d;

   logic [5:0]  r_bit_cnt;
   logic [30:0] r_shift;
   logic        r_cmd_wr;
   logic [6:0]  r_addr;
   logic [31:0] r_data;
   logic [31:0] r_tx;
   logic        r_miso;
   logic        r_commit;
   logic [31:0] r_regs [REG_DEPTH];

   logic        w_sck_s;
   logic        w_cs_s;
   logic        w_mosi_s;
   logic        w_sck_rise;
   logic        w_sck_fall;
   logic        w_cs_fall;
   logic        w_cs_rise;
   logic [6:0]  w_addr_in;
   logic        w_addr_in_ok;
   logic [31:0] w_rd_word;
   logic        w_addr_ok;
   logic        w_host_ok;
   logic        w_commit_wr;

   assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

   assign w_sck_rise = w_sck_s & ~r_sck_d;
   assign w_sck_fall = ~w_sck_s & r_sck_d;
   assign w_cs_fall  = ~w_cs_s & r_cs_d;
   assign w_cs_rise  = w_cs_s & ~r_cs_d;

   // Sync flops reset to the idle line levels so reset release never fakes an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sck_sync  <= '1;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sck_d     <= 1'b1;
         r_cs_d      <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], nSCS};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
         r_sck_d     <= w_sck_s;
         r_cs_d      <= w_cs_s;
      end
   end

   assign w_addr_in    = {r_shift[5:0], w_mosi_s};
   assign w_addr_in_ok = ({1'b0, w_addr_in} < DEPTH8);
   assign w_rd_word    = w_addr_in_ok ? r_regs[w_addr_in[AW-1:0]] : 32'h0;
   assign w_addr_ok    = ({1'b0, r_addr} < DEPTH8);
   assign w_host_ok    = ({1'b0, host_addr} < DEPTH8);
   assign host_rdata   = w_host_ok ? r_regs[host_addr[AW-1:0]] : 32'h0;
   assign w_commit_wr  = (r_state == S_DONE) && r_commit && r_cmd_wr && w_addr_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_cs_fall) w_state_next = S_ADDR;
         S_ADDR: begin
            if (w_cs_rise)                           w_state_next = S_IDLE;
            else if (w_sck_rise && r_bit_cnt == 6'd7) w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_cs_rise)                            w_state_next = S_IDLE;
            else if (w_sck_rise && r_bit_cnt == 6'd39) w_state_next = S_DONE;
         end
         // Level test so a deselect coinciding with the last SCK rise still ends the frame.
         S_DONE: if (w_cs_s) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_cmd_wr    <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_tx        <= '0;
         r_miso      <= 1'b0;
         r_commit    <= 1'b0;
         wr_valid    <= 1'b0;
         rd_valid    <= 1'b0;
         frame_error <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         wr_valid    <= 1'b0;
         rd_valid    <= 1'b0;
         frame_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  r_bit_cnt <= '0;
                  r_miso    <= 1'b0;
                  r_commit  <= 1'b0;
               end
            end
            S_ADDR: begin
               if (w_cs_rise) begin
                  frame_error <= 1'b1;
               end else begin
                  if (w_sck_fall) r_miso <= 1'b0;
                  if (w_sck_rise) begin
                     r_shift   <= {r_shift[29:0], w_mosi_s};
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     if (r_bit_cnt == 6'd7) begin
                        r_cmd_wr <= r_shift[6];
                        r_addr   <= w_addr_in;
                        r_tx     <= w_rd_word;
                     end
                  end
               end
            end
            S_DATA: begin
               if (w_cs_rise) begin
                  frame_error <= 1'b1;
               end else begin
                  if (w_sck_fall) begin
                     r_miso <= r_tx[31];
                     r_tx   <= {r_tx[30:0], 1'b0};
                  end
                  if (w_sck_rise) begin
                     r_shift   <= {r_shift[29:0], w_mosi_s};
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     if (r_bit_cnt == 6'd39) begin
                        r_data   <= {r_shift[30:0], w_mosi_s};
                        r_commit <= 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               if (r_commit) begin
                  r_commit <= 1'b0;
                  if (r_cmd_wr) begin
                     wr_valid <= 1'b1;
                     wr_addr  <= r_addr;
                     wr_data  <= r_data;
                  end else begin
                     rd_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(REG_DEPTH); i++) r_regs[i] <= RESET_VALUE;
      end else if (w_commit_wr) begin
         r_regs[r_addr[AW-1:0]] <= r_data;
      end
   end

   assign MISO    = r_miso;
   assign miso_oe = ~w_cs_s;
   assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_tmc4671_spi_responder.sv
// Bench for tmc4671_spi_responder: SPI mode-3 master, register model and event scoreboard.
`timescale 1ns/1ps
module tb_tmc4671_spi_responder;

   localparam int HALF  = 6;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        SCK, MOSI, nSCS;
   logic        MISO, miso_oe;
   logic        wr_valid, rd_valid, frame_error, busy;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic [6:0]  host_addr;
   logic [31:0] host_rdata;

   typedef struct {
      int          kind;     // 0 write, 1 read, 2 abort
      logic [6:0]  addr;
      logic [31:0] data;
      bit          chk_ad;
   } evt_t;

   evt_t        exp_q[$];
   logic [31:0] mdl [DEPTH];
   int          n_chk  = 0;
   int          n_pass = 0;

   tmc4671_spi_responder dut (
      .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .nSCS(nSCS),
      .MISO(MISO), .miso_oe(miso_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_valid(rd_valid), .frame_error(frame_error),
      .busy(busy), .host_addr(host_addr), .host_rdata(host_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic take_evt(input int kind);
      evt_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_evt", kind, 99);
         return;
      end
      e = exp_q.pop_front();
      chk("evt_kind", kind, e.kind);
      if (kind == 0 && e.chk_ad) begin
         chk("wr_addr", wr_addr, e.addr);
         chk("wr_data", wr_data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (wr_valid)    take_evt(0);
         if (rd_valid)    take_evt(1);
         if (frame_error) take_evt(2);
      end
   end

   task automatic spi_xfer(input logic [39:0] dg, input int nbits, input bit end_cs,
                           output logic [39:0] rx);
      nSCS = 1'b0;
      wclk(6);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         SCK  = 1'b0;
         MOSI = (i < 40) ? dg[39-i] : 1'b0;
         wclk(HALF);
         SCK = 1'b1;
         if (i < 40) rx = {rx[38:0], MISO};
         wclk(HALF);
      end
      wclk(6);
      if (end_cs) begin
         nSCS = 1'b1;
         wclk(8);
      end
   endtask

   task automatic wait_q();
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) wclk(1);
      chk("evt_pending", exp_q.size(), 0);
   endtask

   task automatic do_frame(input bit wr, input logic [6:0] addr, input logic [31:0] data,
                           input int nbits);
      evt_t        e;
      logic [39:0] rx;
      logic [39:0] exp_rx;
      bit          ok;
      ok     = (addr < DEPTH);
      exp_rx = {8'h00, ok ? mdl[addr] : 32'h0};
      e.kind = (nbits < 40) ? 2 : (wr ? 0 : 1);
      e.addr = addr;
      e.data = data;
      e.chk_ad = ok;
      exp_q.push_back(e);
      spi_xfer({wr, addr, data}, nbits, 1'b1, rx);
      if (nbits >= 40) begin
         chk("miso_rx", rx, exp_rx);
         if (wr && ok) mdl[addr] = data;
      end
      wait_q();
   endtask

   task automatic host_chk(input logic [6:0] a);
      host_addr = a;
      #1;
      chk("host_rdata", host_rdata, (a < DEPTH) ? mdl[a] : 32'h0);
   endtask

   initial begin
      logic [39:0] rx;
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      reset = 1'b1; SCK = 1'b1; nSCS = 1'b1; MOSI = 1'b0; host_addr = '0;
      wclk(5);
      chk("rst_miso", MISO, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {wr_valid, rd_valid, frame_error}, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      reset = 1'b0;
      wclk(5);

      do_frame(1'b1, 7'h04, 32'h1111_2222, 40);
      host_chk(7'h04);

      // reset in the middle of a write frame
      spi_xfer({1'b1, 7'h05, 32'h9999_8888}, 20, 1'b0, rx);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      wclk(3);
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      chk("mrst_busy", busy, 0);
      chk("mrst_miso", MISO, 0);
      chk("mrst_oe", miso_oe, 0);
      host_chk(7'h04);
      nSCS = 1'b1; SCK = 1'b1;
      wclk(3);
      reset = 1'b0;
      wclk(5);
      do_frame(1'b1, 7'h05, 32'h5555_AAAA, 40);
      host_chk(7'h05);

      do_frame(1'b1, 7'h01, 32'hDEAD_BEEF, 40);
      host_chk(7'h01);
      do_frame(1'b0, 7'h01, 32'h0, 40);

      do_frame(1'b1, 7'h7F, 32'h1234_5678, 40);
      for (int j = 0; j < DEPTH; j++) host_chk(7'(j));
      host_chk(7'h7F);
      do_frame(1'b0, 7'h7F, 32'h0, 40);

      do_frame(1'b1, 7'h02, 32'hCAFE_F00D, 40);
      do_frame(1'b1, 7'h02, 32'hFFFF_0000, 23);
      host_chk(7'h02);

      do_frame(1'b1, 7'h03, 32'h0000_00A5, 44);
      wclk(20);
      host_chk(7'h03);
      do_frame(1'b0, 7'h03, 32'h0, 40);

      do_frame(1'b1, 7'h01, 32'h0BAD_C0DE, 40);
      host_chk(7'h01);
      chk("end_busy", busy, 0);
      chk("end_oe", miso_oe, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_chk);
      $fatal(1, "timeout");
   end

endmodule
